// File: rtl/periph_obi_demux.sv
// periph_obi_demux: one OBI initiator fanned out to NUM_PORTS peripheral targets.
// Addresses are decoded into fixed windows above 0x2000_0000.
// Accesses that hit no window get an error response.
// Responses return in order, and the order is tracked by a small target-code FIFO.
// New accesses only issue to the same target as the youngest outstanding one.
// This keeps responses in order without reordering buffers.
module periph_obi_demux #(
  parameter int          NUM_PORTS       = 9,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] ERR_RDATA       = 32'hBADACCE5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  // upstream OBI
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic [31:0]               addr_i,
  input  logic                      we_i,
  input  logic [3:0]                be_i,
  input  logic [31:0]               wdata_i,
  output logic                      rvalid_o,
  output logic [31:0]               rdata_o,
  output logic                      err_o,
  // downstream peripherals
  output logic [NUM_PORTS-1:0]      p_req_o,
  input  logic [NUM_PORTS-1:0]      p_gnt_i,
  output logic [31:0]               p_addr_o,
  output logic                      p_we_o,
  output logic [3:0]                p_be_o,
  output logic [31:0]               p_wdata_o,
  input  logic [NUM_PORTS-1:0]      p_rvalid_i,
  input  logic [NUM_PORTS*32-1:0]   p_rdata_i
);

  localparam int TW = $clog2(NUM_PORTS + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [TW-1:0] UNMAPPED = TW'(NUM_PORTS);
  localparam logic [31:0]   BASE     = 32'h2000_0000;
  localparam int            NUM_WIN  = 9;

  // Half-open windows [lo, hi) as offsets from BASE; the gap at idx2 is deliberate.
  localparam logic [31:0] WIN_LO [NUM_WIN] = '{
    32'h0_0000, 32'h1_0000, 32'h2_0000, 32'h3_0000, 32'h4_0000,
    32'h5_0000, 32'h6_0000, 32'h6_8000, 32'h7_0000};
  localparam logic [31:0] WIN_HI [NUM_WIN] = '{
    32'h1_0000, 32'h2_0000, 32'h2_0100, 32'h4_0000, 32'h5_0000,
    32'h6_0000, 32'h6_8000, 32'h7_0000, 32'h8_0000};

  // Addresses below BASE wrap to huge offsets, so they miss every window.
  logic [31:0]          off;
  logic [NUM_PORTS-1:0] hit;
  logic                 dec_mapped;
  logic [TW-1:0]        dec_tgt;

  assign off        = addr_i - BASE;
  assign dec_mapped = |hit;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_win
    if (gi < NUM_WIN) begin : g_real
      assign hit[gi] = (off >= WIN_LO[gi]) && (off < WIN_HI[gi]);
    end else begin : g_none
      assign hit[gi] = 1'b0;
    end
  end

  // Encode the one-hot window hit into a target code; no hit means UNMAPPED.
  always_comb begin
    dec_tgt = UNMAPPED;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (hit[k]) dec_tgt = TW'(k);
    end
  end

  // FIFO and bookkeeping state
  logic [TW-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] last_tgt_q, last_tgt_d;
  logic          err_pend_q, err_pend_d;

  logic fifo_full, fifo_empty, issue_ok, push, pop;

  assign fifo_full  = (count_q == CW'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == '0);
  assign issue_ok   = !fifo_full && (fifo_empty || (dec_tgt == last_tgt_q));

  // Address, we, be and wdata go to every port unchanged; only req is steered.
  assign p_addr_o  = addr_i;
  assign p_we_o    = we_i;
  assign p_be_o    = be_i;
  assign p_wdata_o = wdata_i;

  // Request steering and grant.
  // An unmapped access is granted locally as soon as ordering allows it.
  always_comb begin
    p_req_o = '0;
    gnt_o   = 1'b0;
    if (!rst_i && req_i && issue_ok) begin
      p_req_o = hit;
      gnt_o   = dec_mapped ? |(hit & p_gnt_i) : 1'b1;
    end
  end

  // Response side: select the head target's rvalid and rdata.
  logic [TW-1:0]        head_tgt;
  logic                 head_mapped;
  logic [NUM_PORTS-1:0] head_sel;
  logic [31:0]          head_rdata;

  assign head_tgt    = fifo_q[rd_ptr_q];
  assign head_mapped = (head_tgt != UNMAPPED);

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_head
    assign head_sel[gi] = (head_tgt == TW'(gi));
  end

  // AND-OR mux of the head port's read data.
  always_comb begin
    head_rdata = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (head_sel[k]) head_rdata = head_rdata | p_rdata_i[32*k +: 32];
    end
  end

  // rvalid from anything but the head port is ignored.
  // rdata and err are held at zero unless rvalid is high.
  always_comb begin
    rvalid_o = 1'b0;
    rdata_o  = '0;
    err_o    = 1'b0;
    if (!rst_i && !fifo_empty) begin
      rvalid_o = head_mapped ? |(head_sel & p_rvalid_i) : err_pend_q;
    end
    if (rvalid_o) begin
      rdata_o = head_mapped ? head_rdata : ERR_RDATA;
      err_o   = !head_mapped;
    end
  end

  assign push = gnt_o;     // gnt_o already implies req_i, !full and !rst_i
  assign pop  = rvalid_o;

  // Next state: count and pointers move on push and pop.
  // The error flag arms on an unmapped grant.
  // An unmapped grant can only follow other unmapped entries.
  // Each of those drains the cycle after its grant.
  // So the armed flag always belongs to the entry at the head one cycle later.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    last_tgt_d = last_tgt_q;
    err_pend_d = err_pend_q;
    if (push) begin
      wr_ptr_d   = (wr_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
      last_tgt_d = dec_tgt;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (push && !dec_mapped) err_pend_d = 1'b1;
    else if (pop)            err_pend_d = 1'b0;
  end

  // State registers; reset discards every outstanding entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_tgt_q <= UNMAPPED;
      err_pend_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      last_tgt_q <= last_tgt_d;
      err_pend_q <= err_pend_d;
    end
  end

  // FIFO storage. Entries are cleared on reset so the head is never X.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < MAX_OUTSTANDING; k++) fifo_q[k] <= UNMAPPED;
    end else if (push) begin
      fifo_q[wr_ptr_q] <= dec_tgt;
    end
  end

endmodule

// File: tb/tb_periph_obi_demux.sv
// Testbench for periph_obi_demux.
// A queue-based reference model runs directed scenarios followed by random traffic.
module tb_periph_obi_demux;

  localparam int NP   = 9;
  localparam int MAXO = 2;
  localparam logic [31:0] ERR = 32'hBADACCE5;

  logic          clk = 1'b0;
  logic          rst_i, req_i, gnt_o, we_i, rvalid_o, err_o;
  logic [31:0]   addr_i, wdata_i, rdata_o;
  logic [3:0]    be_i;
  logic [NP-1:0] p_req_o, p_gnt_i, p_rvalid_i;
  logic [31:0]   p_addr_o, p_wdata_o;
  logic          p_we_o;
  logic [3:0]    p_be_o;
  logic [NP*32-1:0] p_rdata_i;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: one queue entry per granted access (target, grant cycle).
  int mq_tgt[$];
  int mq_cyc[$];
  int ncyc = 0;

  always #5 clk = ~clk;

  periph_obi_demux #(.NUM_PORTS(NP), .MAX_OUTSTANDING(MAXO), .ERR_RDATA(ERR)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i), .be_i(be_i),
    .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .p_req_o(p_req_o), .p_gnt_i(p_gnt_i), .p_addr_o(p_addr_o), .p_we_o(p_we_o),
    .p_be_o(p_be_o), .p_wdata_o(p_wdata_o), .p_rvalid_i(p_rvalid_i),
    .p_rdata_i(p_rdata_i)
  );

  // Map an address to its peripheral index, or NP when the address is unmapped.
  function automatic int ref_decode(input logic [31:0] a);
    longint off;
    if (a < 32'h2000_0000 || a >= 32'h2008_0000) return NP;
    off = longint'(a) - 64'h2000_0000;
    if (off < 'h10000) return 0;
    if (off < 'h20000) return 1;
    if (off < 'h20100) return 2;
    if (off < 'h30000) return NP;
    if (off < 'h40000) return 3;
    if (off < 'h50000) return 4;
    if (off < 'h60000) return 5;
    if (off < 'h68000) return 6;
    if (off < 'h70000) return 7;
    return 8;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, ncyc, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check the outputs against the model, then advance the model.
  // When rport >= 0, that port's rdata is rdv; every other port's rdata is random.
  task automatic step(input bit r, input bit rq, input logic [31:0] a,
                      input logic [NP-1:0] g, input logic [NP-1:0] rv,
                      input int rport, input logic [31:0] rdv);
    int tgt, h;
    bit allowed, e_gnt, e_rv, e_err;
    logic [NP-1:0] e_preq;
    logic [31:0] e_rd;
    logic [31:0] prd [NP];
    @(negedge clk);
    rst_i = r; req_i = rq; addr_i = a; we_i = 1'($urandom);
    be_i = 4'($urandom); wdata_i = $urandom; p_gnt_i = g; p_rvalid_i = rv;
    for (int k = 0; k < NP; k++) begin
      prd[k] = (k == rport) ? rdv : $urandom;
      p_rdata_i[32*k +: 32] = prd[k];
    end
    #1;
    tgt     = ref_decode(a);
    allowed = (mq_tgt.size() < MAXO) && (mq_tgt.size() == 0 || mq_tgt[$] == tgt);
    e_preq  = '0;
    e_gnt   = 1'b0;
    e_rv    = 1'b0;
    e_err   = 1'b0;
    e_rd    = '0;
    if (!r) begin
      if (rq && allowed) begin
        if (tgt < NP) begin
          e_preq[tgt] = 1'b1;
          e_gnt = g[tgt];
        end else begin
          e_gnt = 1'b1;
        end
      end
      if (mq_tgt.size() > 0) begin
        h = mq_tgt[0];
        if (h < NP) begin
          e_rv = rv[h];
          if (e_rv) e_rd = prd[h];
        end else if (mq_cyc[0] < ncyc) begin
          e_rv = 1'b1; e_err = 1'b1; e_rd = ERR;
        end
      end
    end
    $display("cyc=%0d rst=%0d req=%0d addr=%h gnt=%0d preq=%b rvalid=%0d err=%0d rdata=%h",
             ncyc, r, rq, a, gnt_o, p_req_o, rvalid_o, err_o, rdata_o);
    chk("p_req",  64'(p_req_o),  64'(e_preq));
    chk("gnt",    64'(gnt_o),    64'(e_gnt));
    chk("rvalid", 64'(rvalid_o), 64'(e_rv));
    chk("err",    64'(err_o),    64'(e_err));
    chk("rdata",  64'(rdata_o),  64'(e_rd));
    chk("bcast",  {p_addr_o, p_wdata_o}, {addr_i, wdata_i});
    chk("bcast_we_be", 64'({p_we_o, p_be_o}), 64'({we_i, be_i}));
    @(posedge clk);
    if (r) begin
      mq_tgt.delete(); mq_cyc.delete();
    end else begin
      if (e_rv) begin
        void'(mq_tgt.pop_front()); void'(mq_cyc.pop_front());
      end
      if (e_gnt) begin
        mq_tgt.push_back(tgt); mq_cyc.push_back(ncyc);
      end
    end
    ncyc++;
  endtask

  // rvalid vector that answers the model's head entry (never a non-head port).
  function automatic logic [NP-1:0] head_rv();
    logic [NP-1:0] v = '0;
    if (mq_tgt.size() > 0 && mq_tgt[0] < NP && mq_cyc[0] < ncyc) v[mq_tgt[0]] = 1'b1;
    return v;
  endfunction

  task automatic drain();
    for (int i = 0; i < 20 && mq_tgt.size() > 0; i++) step(0, 0, 0, '0, head_rv(), -1, 0);
  endtask

  logic [31:0] bnd [8];
  logic [NP-1:0] rv_r;
  logic [31:0] ra;

  initial begin
    rst_i = 1; req_i = 0; addr_i = 0; we_i = 0; be_i = 0; wdata_i = 0;
    p_gnt_i = 0; p_rvalid_i = 0; p_rdata_i = 0;

    // Reset: all outputs must stay low, even with a request and responses present.
    step(1, 1, 32'h2002_0004, '1, '1, -1, 0);
    step(1, 0, 0, '0, '0, -1, 0);

    // Mapped read to idx2, answered on the next cycle.
    step(0, 1, 32'h2002_0004, 9'b0_0000_0100, '0, -1, 0);
    step(0, 0, 0, '0, 9'b0_0000_0100, 2, 32'h1234_5678);

    // Unmapped read inside the idx2 gap: error response on the next cycle.
    step(0, 1, 32'h2002_0100, '1, '0, -1, 0);
    step(0, 0, 0, '0, '0, -1, 0);

    // Back-to-back unmapped reads.
    step(0, 1, 32'h2008_0000, '0, '0, -1, 0);
    step(0, 1, 32'h0000_0000, '0, '0, -1, 0);
    step(0, 0, 0, '0, '0, -1, 0);

    // Three reads to idx5 with responses withheld; the FIFO fills and the third waits.
    step(0, 1, 32'h2005_0000, '1, '0, -1, 0);
    step(0, 1, 32'h2005_0000, '1, '0, -1, 0);
    step(0, 1, 32'h2005_0000, '1, '0, -1, 0);
    step(0, 1, 32'h2005_0000, '1, '0, -1, 0);
    step(0, 1, 32'h2005_0000, '1, 9'b0_0010_0000, 5, 32'hA5A5_0001);
    step(0, 1, 32'h2005_0000, '1, '0, -1, 0);
    drain();

    // idx1 outstanding: an idx8 request is blocked until the idx1 response pops.
    step(0, 1, 32'h2001_0000, '1, '0, -1, 0);
    step(0, 1, 32'h2007_0000, '1, '0, -1, 0);
    step(0, 1, 32'h2007_0000, '1, 9'b0_0000_0010, 1, 32'h0000_1111);
    step(0, 1, 32'h2007_0000, '1, '0, -1, 0);
    drain();

    // Reset mid-flight: a late rvalid is ignored, then a new access works normally.
    step(0, 1, 32'h2006_0000, '1, '0, -1, 0);
    step(0, 1, 32'h2006_0000, '1, '0, -1, 0);
    step(1, 0, 0, '0, '0, -1, 0);
    step(0, 0, 0, '0, 9'b0_0100_0000, 6, 32'hDEAD_0006);
    step(0, 1, 32'h2006_8000, '1, '0, -1, 0);
    drain();

    // Window boundaries.
    bnd = '{32'h2000_FFFF, 32'h2002_00FF, 32'h2002_0100, 32'h2006_7FFF,
            32'h2006_8000, 32'h2007_FFFF, 32'h2008_0000, 32'h1FFF_FFFF};
    for (int i = 0; i < 8; i++) begin
      step(0, 1, bnd[i], '1, '0, -1, 0);
      drain();
    end

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = $urandom;
        1:       ra = 32'h2000_0000 + {12'h0, 4'($urandom_range(0, 8)), 16'h0};
        default: ra = 32'h2000_0000 + $urandom_range(0, 32'h8_FFFF);
      endcase
      rv_r = ($urandom_range(0, 1) == 1) ? head_rv() : '0;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7), ra,
           NP'($urandom), rv_r, -1, 0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
